// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - sequential unsigned restoring divider, one quotient bit per clock
// Optional early divide-by-zero exit: DIV_ZERO_DETECT_EN.
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0] Divisor,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             DivByZero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] quo;
  logic [WIDTH:0]   prem;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   p_shift;
  logic [WIDTH:0]   p_next;
  logic             q_bit;
  logic [WIDTH-1:0] q_next;

  // One WIDTH+1 bit compare/subtract step; the extra bit makes overflow impossible.
  always_comb begin
    p_shift = {prem[WIDTH-1:0], dvd[WIDTH-1]};
    q_bit   = (p_shift >= {1'b0, dvs});
    p_next  = q_bit ? (p_shift - {1'b0, dvs}) : p_shift;
    q_next  = {quo[WIDTH-2:0], q_bit};
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= IDLE;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      Quotient  <= '0;
      Remainder <= '0;
      dvd       <= '0;
      dvs       <= '0;
      quo       <= '0;
      prem      <= '0;
      cnt       <= '0;
`ifdef DIV_ZERO_DETECT_EN
      DivByZero <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          Done <= 1'b0;
          if (Start) begin
            dvd  <= Dividend;
            dvs  <= Divisor;
            prem <= '0;
            quo  <= '0;
            cnt  <= CW'(WIDTH - 1);
`ifdef DIV_ZERO_DETECT_EN
            DivByZero <= 1'b0;
            if (Divisor == '0) begin
              state     <= DONE;
              Done      <= 1'b1;
              Quotient  <= '1;
              Remainder <= Dividend;
              DivByZero <= 1'b1;
            end else begin
              state <= RUN;
              Busy  <= 1'b1;
            end
`else
            state <= RUN;
            Busy  <= 1'b1;
`endif
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          dvd  <= {dvd[WIDTH-2:0], 1'b0};
          prem <= p_next;
          quo  <= q_next;
          if (cnt == '0) begin
            state     <= DONE;
            Busy      <= 1'b0;
            Done      <= 1'b1;
            Quotient  <= q_next;
            Remainder <= p_next[WIDTH-1:0];
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef DIV_ZERO_DETECT_EN
  assign DivByZero = 1'b0;
`endif

endmodule
